// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared field limits and enumerations for the clock datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    typedef enum logic [1:0] {
        LD_SEC = 2'd0,
        LD_MIN = 2'd1,
        LD_HR  = 2'd2
    } ld_sel_t;

    typedef enum logic [1:0] {
        AL_IDLE    = 2'd0,
        AL_RINGING = 2'd1,
        AL_SNOOZED = 2'd2
    } alarm_state_t;

endpackage

`default_nettype wire

// File: rtl/alarm_channel.sv
// ============================================================================
// Module      : alarm_channel
// Description : One alarm channel: config registers, ring FSM, snooze counter.
//               Snooze support is built only with PARAM_CLOCK_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_channel
    import clock_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_wr,
    input  logic [4:0] cfg_hr,
    input  logic [5:0] cfg_min,
    input  logic       cfg_arm,
    input  logic       time_evt,
    input  logic [4:0] time_hr,
    input  logic [5:0] time_min,
    input  logic       min_carry,
    input  logic       stop_alarm,
    input  logic       snooze,
    output logic       ring
);

    alarm_state_t r_state;
    alarm_state_t w_state_nxt;
    logic         r_armed;
    logic [4:0]   r_hr;
    logic [5:0]   r_min;
    logic         w_match;

`ifdef PARAM_CLOCK_SNOOZE_EN
    localparam logic [5:0] c_SNOOZE = 6'(SNOOZE_MIN);
    logic [5:0] r_snz_cnt;
`else
    logic w_unused_snooze;
    assign w_unused_snooze = snooze ^ min_carry ^ (SNOOZE_MIN == 0);
`endif

    // time_evt only fires on tick-produced hh:mm:00 instants, never on loads
    assign w_match = time_evt && r_armed && (time_hr == r_hr) && (time_min == r_min);
    assign ring    = (r_state == AL_RINGING);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            AL_IDLE: begin
                if (w_match) w_state_nxt = AL_RINGING;
            end
            AL_RINGING: begin
                if (stop_alarm) w_state_nxt = AL_IDLE;
`ifdef PARAM_CLOCK_SNOOZE_EN
                else if (snooze) w_state_nxt = AL_SNOOZED;
`endif
            end
`ifdef PARAM_CLOCK_SNOOZE_EN
            AL_SNOOZED: begin
                if (stop_alarm) w_state_nxt = AL_IDLE;
                else if (min_carry && (r_snz_cnt <= 6'd1)) w_state_nxt = AL_RINGING;
            end
`endif
            default: w_state_nxt = AL_IDLE;
        endcase
        if (cfg_wr && !cfg_arm) w_state_nxt = AL_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= AL_IDLE;
            r_armed <= 1'b0;
            r_hr    <= 5'd0;
            r_min   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            if (cfg_wr) begin
                r_armed <= cfg_arm;
                r_hr    <= cfg_hr;
                r_min   <= cfg_min;
            end
        end
    end

`ifdef PARAM_CLOCK_SNOOZE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snz_cnt <= 6'd0;
        end else if (r_state == AL_RINGING && w_state_nxt == AL_SNOOZED) begin
            r_snz_cnt <= c_SNOOZE;
        end else if (r_state == AL_SNOOZED && min_carry && r_snz_cnt != 6'd0) begin
            r_snz_cnt <= r_snz_cnt - 6'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/param_clock_dp.sv
// ============================================================================
// Module      : param_clock_dp
// Description : Prescaler, hh:mm:ss chain, validated loads, 12/24h display and
//               NUM_ALARMS alarm channels. Snooze via PARAM_CLOCK_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_clock_dp
    import clock_pkg::*;
#(
    parameter int DIV        = 1000000,
    parameter int NUM_ALARMS = 2,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  on,
    input  logic                  ld_valid,
    input  logic [1:0]            ld_sel,
    input  logic [5:0]            ld_data,
    output logic                  ld_err,
    input  logic                  mode_12h,
    input  logic                  al_wr,
    input  logic [1:0]            al_idx,
    input  logic [4:0]            al_hr,
    input  logic [5:0]            al_min,
    input  logic                  al_arm,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    output logic [5:0]            sec,
    output logic [5:0]            min,
    output logic [4:0]            hr,
    output logic [4:0]            hr_disp,
    output logic                  pm,
    output logic                  sec_pulse,
    output logic [NUM_ALARMS-1:0] alarm_ring,
    output logic                  alarm_any
);

    localparam int              c_PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(DIV - 1);

    logic [c_PW-1:0] r_presc;
    logic [5:0]      r_sec, r_min;
    logic [4:0]      r_hr;
    logic            r_ld_err;
    logic            w_tick, w_carry_min, w_carry_hr;
    logic            w_ld_ok, w_al_ok, w_evt;
    logic [5:0]      w_sec_nxt, w_min_nxt;
    logic [4:0]      w_hr_nxt;

    assign w_tick      = on && (r_presc == c_PRESC_MAX);
    assign w_carry_min = w_tick && (r_sec == SEC_MAX);
    assign w_carry_hr  = w_carry_min && (r_min == MIN_MAX);

    always_comb begin
        w_ld_ok = 1'b0;
        if (ld_valid) begin
            if (ld_sel == LD_SEC)      w_ld_ok = (ld_data <= SEC_MAX);
            else if (ld_sel == LD_MIN) w_ld_ok = (ld_data <= MIN_MAX);
            else if (ld_sel == LD_HR)  w_ld_ok = (ld_data <= {1'b0, HR_MAX});
        end
    end

    assign w_al_ok = al_wr && (32'(al_idx) < NUM_ALARMS) &&
                     (al_hr <= HR_MAX) && (al_min <= MIN_MAX);

    // A load overrides its own field; the carry into that field is simply lost
    always_comb begin
        w_sec_nxt = r_sec;
        w_min_nxt = r_min;
        w_hr_nxt  = r_hr;
        if (w_tick)      w_sec_nxt = (r_sec == SEC_MAX) ? 6'd0 : r_sec + 6'd1;
        if (w_carry_min) w_min_nxt = (r_min == MIN_MAX) ? 6'd0 : r_min + 6'd1;
        if (w_carry_hr)  w_hr_nxt  = (r_hr == HR_MAX)   ? 5'd0 : r_hr + 5'd1;
        if (w_ld_ok) begin
            if (ld_sel == LD_SEC)      w_sec_nxt = ld_data;
            else if (ld_sel == LD_MIN) w_min_nxt = ld_data;
            else                       w_hr_nxt  = ld_data[4:0];
        end
    end

    assign w_evt = w_carry_min && !w_ld_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc  <= '0;
            r_sec    <= 6'd0;
            r_min    <= 6'd0;
            r_hr     <= 5'd0;
            r_ld_err <= 1'b0;
        end else begin
            if (w_ld_ok && ld_sel == LD_SEC) r_presc <= '0;
            else if (on)                     r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_sec    <= w_sec_nxt;
            r_min    <= w_min_nxt;
            r_hr     <= w_hr_nxt;
            r_ld_err <= (ld_valid && !w_ld_ok) || (al_wr && !w_al_ok);
        end
    end

    always_comb begin
        hr_disp = r_hr;
        if (mode_12h) begin
            if (r_hr == 5'd0)      hr_disp = 5'd12;
            else if (r_hr > 5'd12) hr_disp = r_hr - 5'd12;
        end
    end

    assign sec       = r_sec;
    assign min       = r_min;
    assign hr        = r_hr;
    assign pm        = (r_hr >= 5'd12);
    assign sec_pulse = w_tick;
    assign ld_err    = r_ld_err;
    assign alarm_any = |alarm_ring;

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
        alarm_channel #(
            .SNOOZE_MIN (SNOOZE_MIN)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .cfg_wr     (w_al_ok && (al_idx == 2'(gi))),
            .cfg_hr     (al_hr),
            .cfg_min    (al_min),
            .cfg_arm    (al_arm),
            .time_evt   (w_evt),
            .time_hr    (w_hr_nxt),
            .time_min   (w_min_nxt),
            .min_carry  (w_carry_min),
            .stop_alarm (stop_alarm),
            .snooze     (snooze),
            .ring       (alarm_ring[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_param_clock_dp.sv
// ============================================================================
// Module      : tb_param_clock_dp
// Description : Directed self-checking bench for param_clock_dp (DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_clock_dp;

    localparam int c_DIV = 4;
    localparam int c_NA  = 2;
    localparam int c_SNZ = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            on = 1'b0;
    logic            ld_valid = 1'b0;
    logic [1:0]      ld_sel = 2'd0;
    logic [5:0]      ld_data = 6'd0;
    logic            ld_err;
    logic            mode_12h = 1'b0;
    logic            al_wr = 1'b0;
    logic [1:0]      al_idx = 2'd0;
    logic [4:0]      al_hr = 5'd0;
    logic [5:0]      al_min = 6'd0;
    logic            al_arm = 1'b0;
    logic            stop_alarm = 1'b0;
    logic            snooze = 1'b0;
    logic [5:0]      sec, min;
    logic [4:0]      hr, hr_disp;
    logic            pm, sec_pulse, alarm_any;
    logic [c_NA-1:0] alarm_ring;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    param_clock_dp #(
        .DIV        (c_DIV),
        .NUM_ALARMS (c_NA),
        .SNOOZE_MIN (c_SNZ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .on         (on),
        .ld_valid   (ld_valid),
        .ld_sel     (ld_sel),
        .ld_data    (ld_data),
        .ld_err     (ld_err),
        .mode_12h   (mode_12h),
        .al_wr      (al_wr),
        .al_idx     (al_idx),
        .al_hr      (al_hr),
        .al_min     (al_min),
        .al_arm     (al_arm),
        .stop_alarm (stop_alarm),
        .snooze     (snooze),
        .sec        (sec),
        .min        (min),
        .hr         (hr),
        .hr_disp    (hr_disp),
        .pm         (pm),
        .sec_pulse  (sec_pulse),
        .alarm_ring (alarm_ring),
        .alarm_any  (alarm_any)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_mis++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] s, input logic [5:0] d);
        ld_valid = 1'b1;
        ld_sel   = s;
        ld_data  = d;
        step(1);
        ld_valid = 1'b0;
    endtask

    task automatic load_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        load(2'd2, h);
        load(2'd1, m);
        load(2'd0, s);
    endtask

    task automatic al_cfg(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m, input logic arm);
        al_wr  = 1'b1;
        al_idx = idx;
        al_hr  = h;
        al_min = m;
        al_arm = arm;
        step(1);
        al_wr  = 1'b0;
    endtask

    int hv[5]  = '{0, 12, 13, 23, 1};
    int dv[5]  = '{12, 12, 1, 11, 1};
    int pv[5]  = '{0, 1, 1, 1, 0};

    initial begin
        // reset state
        #12;
        chk_eq("rst_sec", sec, 0);
        chk_eq("rst_min", min, 0);
        chk_eq("rst_hr", hr, 0);
        chk_eq("rst_hr_disp24", hr_disp, 0);
        chk_eq("rst_pm", pm, 0);
        chk_eq("rst_sec_pulse", sec_pulse, 0);
        chk_eq("rst_ld_err", ld_err, 0);
        chk_eq("rst_ring", alarm_ring, 0);
        mode_12h = 1'b1;
        #1;
        chk_eq("rst_hr_disp12", hr_disp, 12);
        mode_12h = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // rollover 23:59:59 -> 00:00:00
        load_time(23, 59, 59);
        on = 1'b1;
        step(3);
        chk_eq("roll_pulse", sec_pulse, 1);
        chk_eq("roll_sec_before", sec, 59);
        step(1);
        chk_eq("roll_sec", sec, 0);
        chk_eq("roll_min", min, 0);
        chk_eq("roll_hr", hr, 0);
        chk_eq("roll_pm", pm, 0);
        chk_eq("roll_pulse_off", sec_pulse, 0);
        on = 1'b0;

        // invalid loads
        load(2'd1, 6'd30);
        chk_eq("ld_min_ok", min, 30);
        chk_eq("ld_min_ok_err", ld_err, 0);
        load(2'd1, 6'd60);
        chk_eq("ld_min60_min", min, 30);
        chk_eq("ld_min60_err", ld_err, 1);
        step(1);
        chk_eq("ld_err_oneshot", ld_err, 0);
        load(2'd3, 6'd5);
        chk_eq("ld_sel3_err", ld_err, 1);
        chk_eq("ld_sel3_sec", sec, 0);
        load(2'd2, 6'd24);
        chk_eq("ld_hr24_err", ld_err, 1);
        chk_eq("ld_hr24_hr", hr, 0);

        // load collides with carry into hour
        load_time(10, 59, 59);
        on = 1'b1;
        step(3);
        ld_valid = 1'b1;
        ld_sel   = 2'd2;
        ld_data  = 6'd5;
        step(1);
        ld_valid = 1'b0;
        on = 1'b0;
        chk_eq("coll_hr", hr, 5);
        chk_eq("coll_min", min, 0);
        chk_eq("coll_sec", sec, 0);
        chk_eq("coll_err", ld_err, 0);

        // 12h display mapping
        mode_12h = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load(2'd2, 6'(hv[i]));
            chk_eq($sformatf("disp12_hr%0d", hv[i]), hr_disp, dv[i]);
            chk_eq($sformatf("pm_hr%0d", hv[i]), pm, pv[i]);
        end
        load(2'd2, 6'd23);
        mode_12h = 1'b0;
        #1;
        chk_eq("disp24_hr23", hr_disp, 23);

        // alarm config validation and ring
        al_cfg(2'd0, 5'd7, 6'd30, 1'b1);
        chk_eq("al_cfg_ok_err", ld_err, 0);
        al_cfg(2'd2, 5'd7, 6'd30, 1'b1);
        chk_eq("al_idx_bad_err", ld_err, 1);
        al_cfg(2'd1, 5'd24, 6'd0, 1'b1);
        chk_eq("al_hr_bad_err", ld_err, 1);
        load_time(7, 29, 58);
        on = 1'b1;
        step(7);
        chk_eq("al_pre_ring", alarm_ring, 0);
        chk_eq("al_pre_sec", sec, 59);
        step(1);
        chk_eq("al_ring", alarm_ring, 2'b01);
        chk_eq("al_any", alarm_any, 1);
        chk_eq("al_min", min, 30);
        on = 1'b0;
        stop_alarm = 1'b1;
        step(1);
        stop_alarm = 1'b0;
        chk_eq("al_stop_ring", alarm_ring, 0);
        chk_eq("al_stop_any", alarm_any, 0);
        load_time(7, 29, 0);
        load(2'd1, 6'd30);
        chk_eq("al_load_min", min, 30);
        chk_eq("al_load_noring", alarm_ring, 0);

        // snooze on channel 1
        al_cfg(2'd1, 5'd6, 6'd0, 1'b1);
        load_time(5, 59, 59);
        on = 1'b1;
        step(4);
        chk_eq("snz_ring", alarm_ring, 2'b10);
        on = 1'b0;
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
`ifdef PARAM_CLOCK_SNOOZE_EN
        chk_eq("snz_silenced", alarm_ring, 2'b00);
`else
        chk_eq("snz_ignored", alarm_ring, 2'b10);
`endif
        on = 1'b1;
        step(1199);
        chk_eq("snz_t_min", min, 4);
        chk_eq("snz_t_sec", sec, 59);
`ifdef PARAM_CLOCK_SNOOZE_EN
        chk_eq("snz_still_quiet", alarm_ring, 2'b00);
`else
        chk_eq("snz_still_ring", alarm_ring, 2'b10);
`endif
        step(1);
        chk_eq("snz_min5", min, 5);
        chk_eq("snz_hr6", hr, 6);
        chk_eq("snz_ring_again", alarm_ring, 2'b10);

        // asynchronous reset mid-operation
        step(2);
        reset = 1'b0;
        #1;
        chk_eq("arst_sec", sec, 0);
        chk_eq("arst_min", min, 0);
        chk_eq("arst_hr", hr, 0);
        chk_eq("arst_ring", alarm_ring, 0);
        chk_eq("arst_any", alarm_any, 0);
        on = 1'b0;
        step(1);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
